// File: rtl/uart_mmio_pkg.sv
// Shared register offsets and FSM state types for the buffered UART MMIO block.
package uart_mmio_pkg;

  localparam logic [3:0] OFF_TX     = 4'h0;
  localparam logic [3:0] OFF_RXSTAT = 4'h2;
  localparam logic [3:0] OFF_RXPOP  = 4'h3;
  localparam logic [3:0] OFF_CSR    = 4'h4;

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;

endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with a combinational head; pushes when full and pops when
// empty are ignored, so a simultaneous push/pop on a non-empty, non-full FIFO keeps count.
module mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Buffered MMIO front end for uart_tx/uart_rx: CPU writes queue into a TX FIFO,
// received bytes queue into an RX FIFO for burst reads.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int         TX_DEPTH    = 16,
  parameter int         RX_DEPTH    = 16,
  parameter logic [3:0] BASE_NIBBLE = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr_en,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  output logic        sel,
  output logic        tx_wr_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_wr_ready,
  input  logic        rx_rd_ready,
  input  logic [7:0]  rx_byte,
  output logic        rx_rd_valid
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [3:0]     offset;
  logic           wr_hit, cpu_tx_push, cpu_rx_pop, csr_wr;
  logic [7:0]     tx_head, rx_head;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic           tx_pop, rx_push;
  logic           tx_ovf_set, rx_ovf_set;

  tx_state_t      tx_state_reg;
  rx_state_t      rx_state_reg;
  logic           tx_wr_valid_reg, rx_rd_valid_reg;
  logic [7:0]     tx_byte_reg;
  logic           tx_ovf_reg, rx_ovf_reg, rx_ready_q_reg;
  logic           unused_bits;

  assign offset      = bus_addr[3:0];
  assign sel         = (bus_addr[31:28] == BASE_NIBBLE);
  assign wr_hit      = bus_wr_en & sel;
  assign cpu_tx_push = wr_hit & (offset == OFF_TX);
  assign cpu_rx_pop  = wr_hit & (offset == OFF_RXPOP);
  assign csr_wr      = wr_hit & (offset == OFF_CSR);
  assign tx_pop      = (tx_state_reg == T_SEND);
  assign rx_push     = (rx_state_reg == R_IDLE) & rx_rd_ready & ~rx_full;
  assign tx_ovf_set  = cpu_tx_push & tx_full;
  // A fresh rd_ready edge during the ack cycle means uart_rx overwrote a byte.
  assign rx_ovf_set  = (rx_state_reg == R_ACK) & rx_rd_ready & ~rx_ready_q_reg;
  assign unused_bits = ^{bus_addr[27:4], bus_wr_data[31:8]};

  assign tx_wr_valid = tx_wr_valid_reg;
  assign tx_byte     = tx_byte_reg;
  assign rx_rd_valid = rx_rd_valid_reg;

  mmio_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(cpu_tx_push), .pop(tx_pop), .din(bus_wr_data[7:0]),
    .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  mmio_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(cpu_rx_pop), .din(rx_byte),
    .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    bus_rd_data = '0;
    case (offset)
      OFF_TX:     bus_rd_data = {31'b0, ~tx_full};
      OFF_RXSTAT: bus_rd_data = {31'b0, ~rx_empty};
      OFF_CSR:    bus_rd_data = {8'b0, 8'(rx_count), 8'(tx_count), 6'b0, rx_ovf_reg, tx_ovf_reg};
      default:    bus_rd_data = {24'b0, rx_head};
    endcase
  end

  // T_WAIT holds off until uart_tx has visibly taken the byte, so one byte never issues twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg    <= T_IDLE;
      tx_wr_valid_reg <= 1'b0;
      tx_byte_reg     <= 8'h00;
    end else begin
      case (tx_state_reg)
        T_IDLE: if (~tx_empty & tx_wr_ready) begin
          tx_state_reg    <= T_SEND;
          tx_wr_valid_reg <= 1'b1;
          tx_byte_reg     <= tx_head;
        end
        T_SEND: begin
          tx_state_reg    <= T_WAIT;
          tx_wr_valid_reg <= 1'b0;
        end
        T_WAIT: if (!tx_wr_ready) tx_state_reg <= T_IDLE;
        default: begin
          tx_state_reg    <= T_IDLE;
          tx_wr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg    <= R_IDLE;
      rx_rd_valid_reg <= 1'b0;
    end else begin
      case (rx_state_reg)
        R_IDLE: if (rx_push) begin
          rx_state_reg    <= R_ACK;
          rx_rd_valid_reg <= 1'b1;
        end
        default: begin
          rx_state_reg    <= R_IDLE;
          rx_rd_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ovf_reg     <= 1'b0;
      rx_ovf_reg     <= 1'b0;
      rx_ready_q_reg <= 1'b0;
    end else begin
      rx_ready_q_reg <= rx_rd_ready;
      if (tx_ovf_set)                      tx_ovf_reg <= 1'b1;
      else if (csr_wr && bus_wr_data[0])   tx_ovf_reg <= 1'b0;
      if (rx_ovf_set)                      rx_ovf_reg <= 1'b1;
      else if (csr_wr && bus_wr_data[1])   rx_ovf_reg <= 1'b0;
    end
  end

endmodule
